// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared definitions for the two-approach intersection controller:
// phase codes, light one-hot constants and light-decode helpers.
// The light encodings match the single traffic light block.
package traffic_phase_scheduler_pkg;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_A_GRN = 3'd1,
        PH_A_YEL = 3'd2,
        PH_A_CLR = 3'd3,
        PH_B_GRN = 3'd4,
        PH_B_YEL = 3'd5,
        PH_B_CLR = 3'd6
    } phase_e;

    localparam logic [3:0] CAR_RED  = 4'b0001;
    localparam logic [3:0] CAR_YEL  = 4'b0010;
    localparam logic [3:0] CAR_GRN  = 4'b0100;
    localparam logic [1:0] WALK_OFF = 2'b01;
    localparam logic [1:0] WALK_ON  = 2'b10;

    // Car light for one approach (side_b selects approach B) in a given phase.
    function automatic logic [3:0] car_light(input phase_e ph, input logic side_b);
        logic [3:0] light;
        light = CAR_RED;
        case (ph)
            PH_A_GRN: light = side_b ? CAR_RED : CAR_GRN;
            PH_A_YEL: light = side_b ? CAR_RED : CAR_YEL;
            PH_B_GRN: light = side_b ? CAR_GRN : CAR_RED;
            PH_B_YEL: light = side_b ? CAR_YEL : CAR_RED;
            default:  light = CAR_RED;
        endcase
        return light;
    endfunction

    // Walker light from the walk-active flag.
    function automatic logic [1:0] walk_light(input logic walk);
        return walk ? WALK_ON : WALK_OFF;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// Phase timer: CNT_W-bit tick counter with clear, saturation and compare flags.
// Clear has priority over counting. Flags describe the count as it will stand
// after the current tick, because every phase decision is taken on a tick; this
// makes a phase of length N last exactly N ticks.
module traffic_phase_scheduler_phase_timer #(
    parameter int CNT_W = 6,
    parameter int MIN_T = 8,
    parameter int MAX_T = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             tick_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             ge_min_o,
    output logic             ge_max_o,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc_s;

    // Saturating increment, next count and compare flags.
    always_comb begin
        cnt_inc_s = cnt_q;
        if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_inc_s = cnt_q;
        end

        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (tick_i) begin
            cnt_d = cnt_inc_s;
        end else begin
            cnt_d = cnt_q;
        end

        ge_min_o = (cnt_inc_s >= CNT_W'(MIN_T));
        ge_max_o = (cnt_inc_s >= CNT_W'(MAX_T));
        done_o   = (cnt_inc_s >= limit_i);
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-approach intersection controller (A/B share one conflict zone).
// Moore machine: green -> yellow -> all-red clearance -> other green, with
// min/max green, demand arbitration and latched pedestrian walk requests.
// All outputs are registered copies of the decoded next state.
// Optional feature: define TRAFFIC_PREEMPT_EN to add the i_preempt_a
// emergency input that forces and holds approach A green.
module traffic_phase_scheduler
    import traffic_phase_scheduler_pkg::*;
#(
    parameter int MIN_GREEN = 8,
    parameter int MAX_GREEN = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 6,
    parameter int CNT_W     = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_tick,
    input  logic       i_start,
    input  logic       i_car_req_a,
    input  logic       i_car_req_b,
    input  logic       i_ped_req_a,
    input  logic       i_ped_req_b,
`ifdef TRAFFIC_PREEMPT_EN
    input  logic       i_preempt_a,
`endif
    output logic [3:0] o_car_a,
    output logic [3:0] o_car_b,
    output logic [1:0] o_walk_a,
    output logic [1:0] o_walk_b,
    output logic [2:0] o_phase,
    output logic       o_busy
);

    phase_e     state_q, state_d;
    logic       ped_a_q, ped_a_d;
    logic       ped_b_q, ped_b_d;
    logic       walk_a_q, walk_a_d;
    logic       walk_b_q, walk_b_d;
    logic [3:0] car_a_q, car_a_d;
    logic [3:0] car_b_q, car_b_d;
    logic [1:0] wlt_a_q, wlt_a_d;
    logic [1:0] wlt_b_q, wlt_b_d;
    logic       busy_q, busy_d;

    logic             preempt_s;
    logic             ge_min_s, ge_max_s, done_s;
    logic [CNT_W-1:0] limit_s;
    logic             timer_clr_s;
    logic             dem_a_s, dem_b_s;
    logic             grant_a_s, grant_b_s;

`ifdef TRAFFIC_PREEMPT_EN
    assign preempt_s = i_preempt_a;
`else
    assign preempt_s = 1'b0;
`endif

    assign dem_a_s     = i_car_req_a | ped_a_q;
    assign dem_b_s     = i_car_req_b | ped_b_q;
    assign timer_clr_s = (state_d != state_q);

    // Per-phase limit for the timer done flag (walk length while green).
    always_comb begin
        limit_s = {CNT_W{1'b0}};
        case (state_q)
            PH_A_GRN, PH_B_GRN: limit_s = CNT_W'(WALK_T);
            PH_A_YEL, PH_B_YEL: limit_s = CNT_W'(YELLOW_T);
            PH_A_CLR, PH_B_CLR: limit_s = CNT_W'(ALLRED_T);
            default:            limit_s = {CNT_W{1'b0}};
        endcase
    end

    traffic_phase_scheduler_phase_timer #(
        .CNT_W (CNT_W),
        .MIN_T (MIN_GREEN),
        .MAX_T (MAX_GREEN)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (timer_clr_s),
        .tick_i   (i_tick),
        .limit_i  (limit_s),
        .ge_min_o (ge_min_s),
        .ge_max_o (ge_max_s),
        .done_o   (done_s)
    );

    // Next-state logic: phase sequencing and demand arbitration.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PH_IDLE: begin
                if (i_tick && i_start) state_d = PH_A_GRN;
                else                   state_d = PH_IDLE;
            end
            PH_A_GRN: begin
                if (!i_tick || preempt_s) begin
                    state_d = PH_A_GRN;
                end else if (!i_start) begin
                    state_d = PH_A_YEL;
                end else if (ge_min_s && dem_b_s && (!i_car_req_a || ge_max_s)) begin
                    state_d = PH_A_YEL;
                end else begin
                    state_d = PH_A_GRN;
                end
            end
            PH_A_YEL: begin
                if (i_tick && done_s) state_d = PH_A_CLR;
                else                  state_d = PH_A_YEL;
            end
            PH_A_CLR: begin
                if (i_tick && done_s) state_d = i_start ? PH_B_GRN : PH_IDLE;
                else                  state_d = PH_A_CLR;
            end
            PH_B_GRN: begin
                if (!i_tick) begin
                    state_d = PH_B_GRN;
                end else if (preempt_s || !i_start) begin
                    state_d = PH_B_YEL;
                end else if (ge_min_s && dem_a_s && (!i_car_req_b || ge_max_s)) begin
                    state_d = PH_B_YEL;
                end else begin
                    state_d = PH_B_GRN;
                end
            end
            PH_B_YEL: begin
                if (i_tick && done_s) state_d = PH_B_CLR;
                else                  state_d = PH_B_YEL;
            end
            PH_B_CLR: begin
                if (i_tick && done_s) state_d = (i_start || preempt_s) ? PH_A_GRN : PH_IDLE;
                else                  state_d = PH_B_CLR;
            end
            default: state_d = PH_IDLE;
        endcase
    end

    // Ped latches and walk flags; a preempted A green grants no walk and keeps the latch.
    always_comb begin
        grant_a_s = (state_d == PH_A_GRN) && (state_q != PH_A_GRN) && !preempt_s;
        grant_b_s = (state_d == PH_B_GRN) && (state_q != PH_B_GRN);

        ped_a_d = i_ped_req_a | (ped_a_q & ~grant_a_s);
        ped_b_d = i_ped_req_b | (ped_b_q & ~grant_b_s);

        walk_a_d = walk_a_q;
        if (state_d != PH_A_GRN) begin
            walk_a_d = 1'b0;
        end else if (grant_a_s) begin
            walk_a_d = ped_a_q;
        end else if (i_tick && done_s) begin
            walk_a_d = 1'b0;
        end else begin
            walk_a_d = walk_a_q;
        end

        walk_b_d = walk_b_q;
        if (state_d != PH_B_GRN) begin
            walk_b_d = 1'b0;
        end else if (grant_b_s) begin
            walk_b_d = ped_b_q;
        end else if (i_tick && done_s) begin
            walk_b_d = 1'b0;
        end else begin
            walk_b_d = walk_b_q;
        end
    end

    // Output decode from the next state so the light registers track the state register.
    always_comb begin
        car_a_d = car_light(state_d, 1'b0);
        car_b_d = car_light(state_d, 1'b1);
        wlt_a_d = walk_light(walk_a_d);
        wlt_b_d = walk_light(walk_b_d);
        busy_d  = (state_d != PH_IDLE);
    end

    // State, latch and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= PH_IDLE;
            ped_a_q  <= 1'b0;
            ped_b_q  <= 1'b0;
            walk_a_q <= 1'b0;
            walk_b_q <= 1'b0;
            car_a_q  <= CAR_RED;
            car_b_q  <= CAR_RED;
            wlt_a_q  <= WALK_OFF;
            wlt_b_q  <= WALK_OFF;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ped_a_q  <= ped_a_d;
            ped_b_q  <= ped_b_d;
            walk_a_q <= walk_a_d;
            walk_b_q <= walk_b_d;
            car_a_q  <= car_a_d;
            car_b_q  <= car_b_d;
            wlt_a_q  <= wlt_a_d;
            wlt_b_q  <= wlt_b_d;
            busy_q   <= busy_d;
        end
    end

    assign o_car_a  = car_a_q;
    assign o_car_b  = car_b_q;
    assign o_walk_a = wlt_a_q;
    assign o_walk_b = wlt_b_q;
    assign o_phase  = state_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with short timing parameters
// (MIN 2, MAX 5, YEL 1, CLR 1, WALK 2) and a tick every cycle.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_traffic_phase_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_tick;
    logic       i_start;
    logic       i_car_req_a, i_car_req_b;
    logic       i_ped_req_a, i_ped_req_b;
    logic       i_preempt_a;
    logic [3:0] o_car_a, o_car_b;
    logic [1:0] o_walk_a, o_walk_b;
    logic [2:0] o_phase;
    logic       o_busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    traffic_phase_scheduler #(
        .MIN_GREEN (2),
        .MAX_GREEN (5),
        .YELLOW_T  (1),
        .ALLRED_T  (1),
        .WALK_T    (2),
        .CNT_W     (6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_tick      (i_tick),
        .i_start     (i_start),
        .i_car_req_a (i_car_req_a),
        .i_car_req_b (i_car_req_b),
        .i_ped_req_a (i_ped_req_a),
        .i_ped_req_b (i_ped_req_b),
`ifdef TRAFFIC_PREEMPT_EN
        .i_preempt_a (i_preempt_a),
`endif
        .o_car_a     (o_car_a),
        .o_car_b     (o_car_b),
        .o_walk_a    (o_walk_a),
        .o_walk_b    (o_walk_b),
        .o_phase     (o_phase),
        .o_busy      (o_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock and check the phase code.
    task automatic step(input logic [2:0] ph);
        @(negedge clk);
        check("phase", {29'd0, o_phase}, {29'd0, ph});
    endtask

    initial begin
        logic [2:0] alt_seq [14];
        alt_seq = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4,
                    3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd6, 3'd1};

        reset = 1'b1; i_tick = 1'b1; i_start = 1'b0;
        i_car_req_a = 1'b0; i_car_req_b = 1'b0;
        i_ped_req_a = 1'b0; i_ped_req_b = 1'b0; i_preempt_a = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // 1: idle, all red
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_car_a", {28'd0, o_car_a}, 32'h1);
            check("idle_car_b", {28'd0, o_car_b}, 32'h1);
            check("idle_walk_a", {30'd0, o_walk_a}, 32'h1);
            check("idle_walk_b", {30'd0, o_walk_b}, 32'h1);
            check("idle_busy", {31'd0, o_busy}, 32'h0);
            check("idle_phase", {29'd0, o_phase}, 32'h0);
        end

        // 2: start with no demand, rest in A green
        i_start = 1'b1;
        step(3'd1);
        check("agrn_car_a", {28'd0, o_car_a}, 32'h4);
        check("agrn_car_b", {28'd0, o_car_b}, 32'h1);
        check("agrn_walk_a", {30'd0, o_walk_a}, 32'h1);
        check("agrn_busy", {31'd0, o_busy}, 32'h1);
        for (int i = 0; i < 19; i++) step(3'd1);

        // 3: B demand only -> yellow, clear, B green; then B green of MIN length
        i_car_req_b = 1'b1;
        step(3'd2);
        check("ayel_car_a", {28'd0, o_car_a}, 32'h2);
        check("ayel_car_b", {28'd0, o_car_b}, 32'h1);
        step(3'd3);
        check("aclr_car_a", {28'd0, o_car_a}, 32'h1);
        check("aclr_car_b", {28'd0, o_car_b}, 32'h1);
        step(3'd4);
        check("bgrn_car_b", {28'd0, o_car_b}, 32'h4);
        check("bgrn_car_a", {28'd0, o_car_a}, 32'h1);
        i_car_req_a = 1'b1; i_car_req_b = 1'b0;
        step(3'd4);
        step(3'd5);
        check("byel_car_b", {28'd0, o_car_b}, 32'h2);
        step(3'd6);
        step(3'd1);

        // 4: both demanding -> MAX_GREEN alternation
        i_car_req_b = 1'b1;
        for (int i = 0; i < 14; i++) step(alt_seq[i]);

        // 5: ped press during B green served on next A green; mid-green press deferred
        for (int i = 0; i < 4; i++) step(3'd1);
        step(3'd2); step(3'd3); step(3'd4);
        i_ped_req_a = 1'b1;
        step(3'd4);
        i_ped_req_a = 1'b0;
        check("bgrn_walk_a", {30'd0, o_walk_a}, 32'h1);
        step(3'd4); step(3'd4); step(3'd4);
        step(3'd5); step(3'd6);
        step(3'd1);
        check("walk1_on0", {30'd0, o_walk_a}, 32'h2);
        check("walk1_b_off", {30'd0, o_walk_b}, 32'h1);
        step(3'd1);
        check("walk1_on1", {30'd0, o_walk_a}, 32'h2);
        step(3'd1);
        check("walk1_end", {30'd0, o_walk_a}, 32'h1);
        i_ped_req_a = 1'b1;
        step(3'd1);
        i_ped_req_a = 1'b0;
        check("mid_press_no_walk", {30'd0, o_walk_a}, 32'h1);
        step(3'd1); step(3'd2); step(3'd3);
        for (int i = 0; i < 5; i++) step(3'd4);
        step(3'd5); step(3'd6);
        step(3'd1);
        check("walk2_on0", {30'd0, o_walk_a}, 32'h2);
        step(3'd1);
        check("walk2_on1", {30'd0, o_walk_a}, 32'h2);
        step(3'd1);
        check("walk2_end", {30'd0, o_walk_a}, 32'h1);
        step(3'd1); step(3'd1); step(3'd2); step(3'd3); step(3'd4);

        // 6: stop during fresh B green -> wind down to idle
        i_start = 1'b0;
        step(3'd5);
        step(3'd6);
        check("wind_clr_car_b", {28'd0, o_car_b}, 32'h1);
        step(3'd0);
        check("wind_busy", {31'd0, o_busy}, 32'h0);
        check("wind_car_a", {28'd0, o_car_a}, 32'h1);
        check("wind_car_b", {28'd0, o_car_b}, 32'h1);
        step(3'd0);

        // Restart: latch was cleared when served, so no walk now
        i_start = 1'b1;
        step(3'd1);
        check("latch_cleared", {30'd0, o_walk_a}, 32'h1);

`ifdef TRAFFIC_PREEMPT_EN
        for (int i = 0; i < 4; i++) step(3'd1);
        step(3'd2); step(3'd3); step(3'd4);
        i_preempt_a = 1'b1;
        step(3'd5);
        i_preempt_a = 1'b0;
        step(3'd6);
        step(3'd1);
`endif

        // Mid-operation reset returns to idle on the next clock
        step(3'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_phase", {29'd0, o_phase}, 32'h0);
        check("rst_car_a", {28'd0, o_car_a}, 32'h1);
        check("rst_walk_a", {30'd0, o_walk_a}, 32'h1);
        check("rst_busy", {31'd0, o_busy}, 32'h0);
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
